nonrestoring_divider: RTL and testbench
=======================================

NONRESTORING_DIVIDER -- requirements
Module: nonrestoring_divider

Interface
REQ-001 The block SHALL have parameter WIDTH, default 16, giving the operand, quotient and remainder width in bits.
REQ-002 The block SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-003 The block SHALL have port clr, input, 1 bit: reset, synchronous and active-high.
REQ-004 The block SHALL have port start, input, 1 bit: request, sampled in IDLE only.
REQ-005 The block SHALL have port data_in, input, WIDTH bits: the dividend in the start cycle, the divisor in the following cycle.
REQ-006 The block SHALL have port busy, output, 1 bit: high in every state except IDLE and DONE.
REQ-007 The block SHALL have port done, output, 1 bit: a one-cycle pulse when results are valid.
REQ-008 The block SHALL have port quot, output, WIDTH bits: the quotient.
REQ-009 The block SHALL have port rem, output, WIDTH bits: the remainder.
REQ-010 The block SHALL have port dbz, output, 1 bit: divide-by-zero flag, valid with done.

Function
REQ-011 The FSM SHALL have states IDLE, LOADM, CHECK, ITER, FIX and DONE.
REQ-012 IDLE SHALL capture data_in as the dividend and go to LOADM on an edge where start=1, and otherwise stay in IDLE.
REQ-013 LOADM SHALL capture data_in as the divisor and go to CHECK.
REQ-014 CHECK SHALL go to DONE when the divisor is 0, setting dbz=1, quot=all-ones and rem=dividend.
REQ-015 When the divisor is nonzero, CHECK SHALL clear the accumulator A (WIDTH+1 bits), load the iteration counter with WIDTH and go to ITER.
REQ-016 Each ITER edge SHALL perform one non-restoring step: shift {A,Q} left one bit; A-=M if A was >=0, else A+=M; set the new Q[0]=~A[sign]; decrement the counter.
REQ-017 ITER SHALL go to FIX on the edge where the counter reaches 0.
REQ-018 FIX SHALL add M to A if A<0, apply the result sign correction, register quot and rem, and go to DONE.
REQ-019 DONE SHALL hold done=1 for exactly one cycle and then go to IDLE.
REQ-020 quot, rem and dbz SHALL hold their values until the next CHECK or FIX update.
REQ-021 If start is sampled at edge E, done SHALL be high in the cycle after edge E+19 (E+2 for divide-by-zero).
REQ-022 start SHALL be ignored in every state except IDLE, and SHALL NOT queue.
REQ-023 Back-to-back operation SHALL be allowed: start may be asserted in the cycle after done.
REQ-024 All arithmetic SHALL wrap to the register width; there SHALL be no overflow flag.

Reset
REQ-025 When clr=1 at an edge, the block SHALL go to IDLE and set quot=0, rem=0, dbz=0, done=0, busy=0, counter=0 and A=0.
REQ-026 clr SHALL take priority over start and over any in-progress operation; an aborted operation SHALL never assert done.

Configuration
REQ-027 With macro DIV_SIGNED_EN defined, operands SHALL be two's complement: magnitudes are divided, the quotient is truncated toward zero, the remainder takes the dividend's sign, and -2^(WIDTH-1)/-1 SHALL give quot=16'h8000 and rem=0.
REQ-028 Without DIV_SIGNED_EN, operands SHALL be unsigned and the FIX sign correction SHALL be absent.
REQ-029 Latency SHALL be identical in both builds.

Structure
REQ-030 Package div_pkg SHALL hold the default WIDTH constant and the state enum typedef (IDLE..DONE).
REQ-031 The add/subtract datapath SHALL be one sub-module, div_addsub (combinational A +/- M, WIDTH+1 bits); the FSM, counter and registers SHALL be in nonrestoring_divider.

Verification
REQ-032 Unsigned/signed: 100 then 7 -> done at E+19, quot=14, rem=2, dbz=0.
REQ-033 Signed build: -100 (16'hFF9C) then 7 -> quot=16'hFFF2, rem=16'hFFFE; 100 then -7 -> quot=16'hFFF2, rem=2.
REQ-034 5 then 0 -> done at E+2, dbz=1, quot=16'hFFFF, rem=5.
REQ-035 Unsigned build: 16'hFFFF then 2 -> quot=16'h7FFF, rem=1; signed build: 16'h8000 then 16'hFFFF -> quot=16'h8000, rem=0.
REQ-036 A start pulse during ITER SHALL be ignored: the first result is unchanged and there is no second done.
REQ-037 clr asserted on the fifth ITER edge -> IDLE next cycle, all outputs 0, no done; a new 9/3 operation then returns quot=3, rem=0.

Source files
------------

// File: rtl/div_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : div_pkg
//  Description : Shared constants and FSM state type for the non-restoring
//                divider.
//  Revision    : 1.0 - initial release
// ============================================================================
package div_pkg;

    localparam int DIV_WIDTH = 16;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        LOADM = 3'd1,
        CHECK = 3'd2,
        ITER  = 3'd3,
        FIX   = 3'd4,
        DONE  = 3'd5
    } state_t;

endpackage : div_pkg
`default_nettype wire

// File: rtl/div_addsub.sv
`default_nettype none
// ============================================================================
//  Module      : div_addsub
//  Description : Combinational WIDTH+1 bit accumulator add/subtract of the
//                zero-extended divisor magnitude.
//  Revision    : 1.0 - initial release
// ============================================================================
module div_addsub
    import div_pkg::*;
#(
    parameter int WIDTH = DIV_WIDTH
) (
    input  logic [WIDTH:0]   a_i,
    input  logic [WIDTH-1:0] m_i,
    input  logic             sub_i,
    output logic [WIDTH:0]   sum_o
);

    // A - M when sub_i is set, otherwise A + M; wraps to WIDTH+1 bits
    always_comb begin
        sum_o = sub_i ? (a_i - {1'b0, m_i}) : (a_i + {1'b0, m_i});
    end

endmodule : div_addsub
`default_nettype wire

// File: rtl/nonrestoring_divider.sv
`default_nettype none
// ============================================================================
//  Module      : nonrestoring_divider
//  Description : Multi-cycle non-restoring divider. Dividend is presented on
//                data_in with start, divisor on the following cycle. One
//                quotient bit per ITER cycle, followed by a FIX cycle.
//                Define DIV_SIGNED_EN for two's complement operands (magnitudes
//                are divided, quotient truncates toward zero, remainder takes
//                the dividend's sign). Latency is the same in both builds.
//  Revision    : 1.0 - initial release
// ============================================================================
module nonrestoring_divider
    import div_pkg::*;
#(
    parameter int WIDTH = DIV_WIDTH
) (
    input  logic             clk,
    input  logic             clr,
    input  logic             start,
    input  logic [WIDTH-1:0] data_in,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] quot,
    output logic [WIDTH-1:0] rem,
    output logic             dbz
);

    localparam int CW = $clog2(WIDTH + 1);

    state_t           state_q;
    logic [WIDTH:0]   a_q;      // signed partial remainder
    logic [WIDTH-1:0] q_q;      // dividend magnitude shifting out, quotient in
    logic [WIDTH-1:0] m_q;      // divisor magnitude
    logic [WIDTH-1:0] dvd_q;    // dividend as presented (needed for dbz rem)
    logic [CW-1:0]    cnt_q;

    logic [WIDTH-1:0] w_din_mag;
    logic [WIDTH-1:0] w_dvd_mag;
    logic [WIDTH:0]   w_shift_a;
    logic [WIDTH:0]   w_as_a;
    logic             w_as_sub;
    logic [WIDTH:0]   w_as_sum;
    logic [WIDTH:0]   w_a_fix;
    logic [WIDTH-1:0] w_quot_fix;
    logic [WIDTH-1:0] w_rem_fix;

    // The shared add/sub performs the iteration step in ITER and the final
    // restore (A + M) in FIX.
    assign w_shift_a = {a_q[WIDTH-1:0], q_q[WIDTH-1]};
    assign w_as_a    = (state_q == FIX) ? a_q : w_shift_a;
    assign w_as_sub  = (state_q == ITER) && !a_q[WIDTH];
    assign w_a_fix   = a_q[WIDTH] ? w_as_sum : a_q;

    div_addsub #(.WIDTH(WIDTH)) u_addsub (
        .a_i   (w_as_a),
        .m_i   (m_q),
        .sub_i (w_as_sub),
        .sum_o (w_as_sum)
    );

`ifdef DIV_SIGNED_EN
    logic dvs_neg_q;

    assign w_din_mag  = data_in[WIDTH-1] ? -data_in : data_in;
    assign w_dvd_mag  = dvd_q[WIDTH-1] ? -dvd_q : dvd_q;
    assign w_quot_fix = (dvd_q[WIDTH-1] ^ dvs_neg_q) ? -q_q : q_q;
    assign w_rem_fix  = dvd_q[WIDTH-1] ? -w_a_fix[WIDTH-1:0] : w_a_fix[WIDTH-1:0];
`else
    assign w_din_mag  = data_in;
    assign w_dvd_mag  = dvd_q;
    assign w_quot_fix = q_q;
    assign w_rem_fix  = w_a_fix[WIDTH-1:0];
`endif

    // Control FSM with registered outputs; clr overrides everything
    always_ff @(posedge clk) begin
        if (clr) begin
            state_q <= IDLE;
            a_q     <= '0;
            q_q     <= '0;
            m_q     <= '0;
            dvd_q   <= '0;
            cnt_q   <= '0;
            quot    <= '0;
            rem     <= '0;
            dbz     <= 1'b0;
            done    <= 1'b0;
            busy    <= 1'b0;
`ifdef DIV_SIGNED_EN
            dvs_neg_q <= 1'b0;
`endif
        end else begin
            done <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (start) begin
                        dvd_q   <= data_in;
                        busy    <= 1'b1;
                        state_q <= LOADM;
                    end
                end
                LOADM: begin
                    m_q     <= w_din_mag;
`ifdef DIV_SIGNED_EN
                    dvs_neg_q <= data_in[WIDTH-1];
`endif
                    state_q <= CHECK;
                end
                CHECK: begin
                    if (m_q == '0) begin
                        dbz     <= 1'b1;
                        quot    <= '1;
                        rem     <= dvd_q;
                        done    <= 1'b1;
                        busy    <= 1'b0;
                        state_q <= DONE;
                    end else begin
                        a_q     <= '0;
                        q_q     <= w_dvd_mag;
                        cnt_q   <= CW'(WIDTH);
                        state_q <= ITER;
                    end
                end
                ITER: begin
                    a_q   <= w_as_sum;
                    q_q   <= {q_q[WIDTH-2:0], ~w_as_sum[WIDTH]};
                    cnt_q <= cnt_q - CW'(1);
                    if (cnt_q == CW'(1)) begin
                        state_q <= FIX;
                    end
                end
                FIX: begin
                    a_q     <= w_a_fix;
                    quot    <= w_quot_fix;
                    rem     <= w_rem_fix;
                    dbz     <= 1'b0;
                    done    <= 1'b1;
                    busy    <= 1'b0;
                    state_q <= DONE;
                end
                DONE: begin
                    state_q <= IDLE;
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

endmodule : nonrestoring_divider
`default_nettype wire

// File: tb/tb_nonrestoring_divider.sv
`default_nettype none
// ============================================================================
//  Module      : tb_nonrestoring_divider
//  Description : Scoreboard bench for nonrestoring_divider. The driver pushes
//                hand-computed results; the monitor pops and compares on done.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_nonrestoring_divider;

    typedef struct {
        logic [15:0] q;
        logic [15:0] r;
        logic        z;
        int          at;
    } exp_t;

    logic        clk = 1'b0;
    logic        clr = 1'b1;
    logic        start = 1'b0;
    logic [15:0] data_in = '0;
    logic        busy, done, dbz;
    logic [15:0] quot, rem;

    int   cyc = 0;
    exp_t sb[$];
    int   n_cmp = 0;
    int   n_bad = 0;
    int   zero_req = 0, zero_ack = 0;
    int   busy_req = 0, busy_ack = 0;

    nonrestoring_divider #(.WIDTH(16)) dut (
        .clk     (clk),
        .clr     (clr),
        .start   (start),
        .data_in (data_in),
        .busy    (busy),
        .done    (done),
        .quot    (quot),
        .rem     (rem),
        .dbz     (dbz)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Monitor: sole owner of the comparison counters
    always @(negedge clk) begin
        if (zero_req != zero_ack) begin
            zero_ack = zero_req;
            n_cmp += 5;
            if (quot !== 16'h0) begin n_bad++; $display("FAIL zero_quot: got %h want 0000", quot); end
            if (rem  !== 16'h0) begin n_bad++; $display("FAIL zero_rem: got %h want 0000", rem); end
            if (dbz  !== 1'b0)  begin n_bad++; $display("FAIL zero_dbz: got %b want 0", dbz); end
            if (done !== 1'b0)  begin n_bad++; $display("FAIL zero_done: got %b want 0", done); end
            if (busy !== 1'b0)  begin n_bad++; $display("FAIL zero_busy: got %b want 0", busy); end
        end
        if (busy_req != busy_ack) begin
            busy_ack = busy_req;
            n_cmp++;
            if (busy !== 1'b1) begin n_bad++; $display("FAIL busy_after_start: got %b want 1", busy); end
        end
        if (done === 1'b1) begin
            if (sb.size() == 0) begin
                n_cmp++; n_bad++;
                $display("FAIL unexpected_done: cycle %0d quot=%h rem=%h dbz=%b", cyc, quot, rem, dbz);
            end else begin
                exp_t e;
                e = sb.pop_front();
                n_cmp += 4;
                if (quot !== e.q) begin n_bad++; $display("FAIL quot: got %h want %h", quot, e.q); end
                if (rem  !== e.r) begin n_bad++; $display("FAIL rem: got %h want %h", rem, e.r); end
                if (dbz  !== e.z) begin n_bad++; $display("FAIL dbz: got %b want %b", dbz, e.z); end
                if (cyc  !== e.at) begin n_bad++; $display("FAIL latency: done at cycle %0d want %0d", cyc, e.at); end
            end
        end else if (sb.size() != 0 && cyc > sb[0].at + 4) begin
            exp_t e;
            e = sb.pop_front();
            n_cmp++; n_bad++;
            $display("FAIL no_done: nothing by cycle %0d, expected at %0d", cyc, e.at);
        end
    end

    task automatic do_op(input logic [15:0] a, input logic [15:0] b,
                         input logic [15:0] q, input logic [15:0] r, input logic z);
        exp_t e;
        @(negedge clk);
        start   = 1'b1;
        data_in = a;
        @(posedge clk);
        #1;
        e.q  = q;
        e.r  = r;
        e.z  = z;
        e.at = cyc + (z ? 2 : 19);
        sb.push_back(e);
        busy_req++;
        start   = 1'b0;
        data_in = b;
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (sb.size() != 0 && n < 60) begin
            @(negedge clk);
            #1;
            n++;
        end
    endtask

    task automatic run(input logic [15:0] a, input logic [15:0] b,
                       input logic [15:0] q, input logic [15:0] r, input logic z);
        do_op(a, b, q, r, z);
        drain();
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int e0;
        repeat (3) @(posedge clk);
        #1;
        clr = 1'b0;
        zero_req++;
        repeat (2) @(negedge clk);

        // Main function, back-to-back
        run(16'd100, 16'd7, 16'd14, 16'd2, 1'b0);
        run(16'd5, 16'd0, 16'hFFFF, 16'd5, 1'b1);
        run(16'd9, 16'd3, 16'd3, 16'd0, 1'b0);
        run(16'd7, 16'd100, 16'd0, 16'd7, 1'b0);
`ifdef DIV_SIGNED_EN
        run(16'hFF9C, 16'd7, 16'hFFF2, 16'hFFFE, 1'b0);
        run(16'd100, 16'hFFF9, 16'hFFF2, 16'd2, 1'b0);
        run(16'hFF9C, 16'hFFF9, 16'd14, 16'hFFFE, 1'b0);
        run(16'h8000, 16'hFFFF, 16'h8000, 16'h0000, 1'b0);
        run(16'hFFFB, 16'd0, 16'hFFFF, 16'hFFFB, 1'b1);
`else
        run(16'hFFFF, 16'd2, 16'h7FFF, 16'd1, 1'b0);
        run(16'hABCD, 16'h0010, 16'h0ABC, 16'h000D, 1'b0);
        run(16'hFFFF, 16'hFFFF, 16'd1, 16'd0, 1'b0);
        run(16'd0, 16'd5, 16'd0, 16'd0, 1'b0);
        run(16'h8000, 16'd3, 16'h2AAA, 16'd2, 1'b0);
`endif

        // A start pulse in ITER must be ignored and must not queue
        do_op(16'd100, 16'd7, 16'd14, 16'd2, 1'b0);
        repeat (8) @(negedge clk);
        start   = 1'b1;
        data_in = 16'd50;
        @(negedge clk);
        start   = 1'b0;
        drain();
        repeat (25) @(negedge clk);

        // clr on the fifth ITER edge aborts without done
        @(negedge clk);
        start   = 1'b1;
        data_in = 16'd100;
        @(posedge clk);
        #1;
        e0      = cyc;
        start   = 1'b0;
        data_in = 16'd7;
        while (cyc < e0 + 6) begin
            @(posedge clk);
            #1;
        end
        clr = 1'b1;
        @(posedge clk);
        #1;
        clr = 1'b0;
        zero_req++;
        repeat (30) @(negedge clk);

        run(16'd9, 16'd3, 16'd3, 16'd0, 1'b0);
        repeat (3) @(negedge clk);
        #1;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule : tb_nonrestoring_divider
`default_nettype wire
